// File: rtl/capp_sequencer.sv
// -----------------------------------------------------------------------------
// capp_sequencer
//   Command-level controller for the CAPP array (compare / cells / tags).
//   It accepts one command at a time and expands it into timed pulses on set,
//   perform_search, select_first and write_lines. It drives comparand and mask,
//   then reports whether any tag is set.
//
//   Commands (cmd_op): 00 SEARCH, 01 SELECT_FIRST, 10 WRITE, 11 SEARCH_SELECT.
//
// Ports
//   CLK, RST_N                    clock / synchronous active-low reset
//   cmd_valid, cmd_ready          command handshake (ready only in IDLE)
//   cmd_op, cmd_data, cmd_mask    command, key/value, bit mask (1 = participates)
//   comparand, mask               to compare block, held until the next accept
//   set, perform_search,
//   select_first                  timed pulses to tags / compare
//   write_lines                   to cells: bit 2i = 1-write, bit 2i+1 = 0-write
//   tag_wires                     tag state from the tags block
//   busy                          ~cmd_ready
//   rsp_valid, rsp_hit, rsp_err   one-cycle response at the end of every command
//
// Optional feature macro: CAPP_SEQ_WRITE_GUARD_EN
//   When defined, WRITE and SEARCH_SELECT check |tag_wires first. A WRITE with
//   no tag set goes straight to RESP. A SEARCH_SELECT with no hit after
//   SRCH_GAP skips the select phase. Both of these cases report rsp_err=1.
//   When the macro is not defined, the full sequence always runs and rsp_err
//   stays 0.
// -----------------------------------------------------------------------------
module capp_sequencer #(
    parameter int WIDTH    = 32,
    parameter int CELLS    = 100,
    parameter int SET_CYC  = 10,
    parameter int SRCH_CYC = 10,
    parameter int SEL_CYC  = 2,
    parameter int WR_CYC   = 10,
    parameter int GAP_CYC  = 10,
    parameter int SEL_GAP  = 2,
    parameter int WR_GAP   = 100
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [WIDTH-1:0]     cmd_data,
    input  logic [WIDTH-1:0]     cmd_mask,
    output logic [WIDTH-1:0]     comparand,
    output logic [WIDTH-1:0]     mask,
    output logic                 set,
    output logic                 perform_search,
    output logic                 select_first,
    output logic [2*WIDTH-1:0]   write_lines,
    input  logic [CELLS-1:0]     tag_wires,
    output logic                 busy,
    output logic                 rsp_valid,
    output logic                 rsp_hit,
    output logic                 rsp_err
);

`ifdef CAPP_SEQ_WRITE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    generate
        if (SET_CYC < 1 || SRCH_CYC < 1 || SEL_CYC < 1 || WR_CYC < 1 ||
            GAP_CYC < 1 || SEL_GAP < 1 || WR_GAP < 1) begin : g_bad_timing
            $error("capp_sequencer: every *_CYC / *_GAP parameter must be >= 1");
        end
    endgenerate

    localparam logic [1:0] OP_SEARCH = 2'b00;
    localparam logic [1:0] OP_SELECT = 2'b01;
    localparam logic [1:0] OP_WRITE  = 2'b10;
    localparam logic [1:0] OP_SS     = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_SET, S_SET_GAP, S_SRCH, S_SRCH_GAP,
        S_SEL, S_SEL_GAP, S_WR, S_WR_GAP, S_RESP
    } state_t;

    state_t             state_reg, state_next;
    logic [31:0]        cnt_reg, cnt_next;
    logic [1:0]         op_reg, op_next;
    logic               err_reg, err_next;
    logic               accept;
    logic               any_tag;
    logic               last_cycle;
    logic [WIDTH-1:0]   data_next, mask_next;
    logic [2*WIDTH-1:0] wl_pattern;

    assign cmd_ready  = (state_reg == S_IDLE);
    assign busy       = ~cmd_ready;
    assign accept     = cmd_valid && (state_reg == S_IDLE);
    assign any_tag    = |tag_wires;
    assign last_cycle = (cnt_reg == 32'd1);

    // Data and mask are latched on the accept edge. The write pattern is
    // built from the values being latched. This lets WR, which is entered on
    // that same edge, drive the new value from its first cycle.
    assign data_next = accept ? cmd_data : comparand;
    assign mask_next = accept ? cmd_mask : mask;
    assign op_next   = accept ? cmd_op   : op_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_wl
            assign wl_pattern[2*gi]   =  data_next[gi] & mask_next[gi];
            assign wl_pattern[2*gi+1] = ~data_next[gi] & mask_next[gi];
        end
    endgenerate

    // Next-state / counter logic. The counter is loaded with the state's
    // length on entry. The state is left on the cycle the counter reads 1.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    err_next = 1'b0;
                    case (cmd_op)
                        OP_SEARCH, OP_SS: begin
                            state_next = S_SET;
                            cnt_next   = 32'(SET_CYC);
                        end
                        OP_SELECT: begin
                            state_next = S_SEL;
                            cnt_next   = 32'(SEL_CYC);
                        end
                        default: begin
                            if (GUARD_EN && !any_tag) begin
                                state_next = S_RESP;
                                err_next   = 1'b1;
                            end else begin
                                state_next = S_WR;
                                cnt_next   = 32'(WR_CYC);
                            end
                        end
                    endcase
                end
            end
            S_SET:      if (last_cycle) begin state_next = S_SET_GAP; cnt_next = 32'(GAP_CYC);  end
                        else cnt_next = cnt_reg - 32'd1;
            S_SET_GAP:  if (last_cycle) begin state_next = S_SRCH;    cnt_next = 32'(SRCH_CYC); end
                        else cnt_next = cnt_reg - 32'd1;
            S_SRCH:     if (last_cycle) begin state_next = S_SRCH_GAP; cnt_next = 32'(GAP_CYC); end
                        else cnt_next = cnt_reg - 32'd1;
            S_SRCH_GAP: begin
                if (!last_cycle) begin
                    cnt_next = cnt_reg - 32'd1;
                end else if (op_reg != OP_SS) begin
                    state_next = S_RESP;
                end else if (GUARD_EN && !any_tag) begin
                    state_next = S_RESP;
                    err_next   = 1'b1;
                end else begin
                    state_next = S_SEL;
                    cnt_next   = 32'(SEL_CYC);
                end
            end
            S_SEL:      if (last_cycle) begin state_next = S_SEL_GAP; cnt_next = 32'(SEL_GAP); end
                        else cnt_next = cnt_reg - 32'd1;
            S_SEL_GAP:  if (last_cycle) state_next = S_RESP;
                        else cnt_next = cnt_reg - 32'd1;
            S_WR:       if (last_cycle) begin state_next = S_WR_GAP; cnt_next = 32'(WR_GAP); end
                        else cnt_next = cnt_reg - 32'd1;
            S_WR_GAP:   if (last_cycle) state_next = S_RESP;
                        else cnt_next = cnt_reg - 32'd1;
            S_RESP:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // The pulse outputs are registered from state_next, so each one is high
    // exactly while its state is current. The response is registered out of
    // RESP, so it appears on the same cycle that cmd_ready returns.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            op_reg         <= '0;
            err_reg        <= 1'b0;
            comparand      <= '0;
            mask           <= '0;
            set            <= 1'b0;
            perform_search <= 1'b0;
            select_first   <= 1'b0;
            write_lines    <= '0;
            rsp_valid      <= 1'b0;
            rsp_hit        <= 1'b0;
            rsp_err        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            op_reg         <= op_next;
            err_reg        <= err_next;
            comparand      <= data_next;
            mask           <= mask_next;
            set            <= (state_next == S_SET);
            perform_search <= (state_next == S_SRCH);
            select_first   <= (state_next == S_SEL);
            write_lines    <= (state_next == S_WR) ? wl_pattern : '0;
            rsp_valid      <= (state_reg == S_RESP);
            rsp_hit        <= (state_reg == S_RESP) && any_tag;
            rsp_err        <= (state_reg == S_RESP) && err_reg && GUARD_EN;
        end
    end

endmodule

// File: tb/tb_capp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_capp_sequencer
//   Directed bench for capp_sequencer with default parameters. Each scenario
//   is a task that drives a command and observes the pulse timing relative to
//   the accept edge. The expected cycle numbers are hand-derived constants.
//   Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_capp_sequencer;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [31:0]  cmd_data, cmd_mask;
    logic [31:0]  comparand, mask;
    logic         set, perform_search, select_first;
    logic [63:0]  write_lines;
    logic [99:0]  tag_wires;
    logic         busy, rsp_valid, rsp_hit, rsp_err;

    int checks = 0;
    int errors = 0;

    // Observations of one command; n = posedges since the accept edge.
    int          obs_rsp_n;
    int          obs_set_first, obs_set_cnt;
    int          obs_srch_first, obs_srch_cnt;
    int          obs_sel_first, obs_sel_cnt;
    int          obs_wr_first, obs_wr_cnt;
    logic [63:0] obs_wl;
    logic        obs_wl_varies;
    logic        obs_hit, obs_err;

    capp_sequencer dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .comparand(comparand), .mask(mask),
        .set(set), .perform_search(perform_search), .select_first(select_first),
        .write_lines(write_lines), .tag_wires(tag_wires),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_err(rsp_err)
    );

    always #5 CLK = ~CLK;

    // Issue one command from a falling edge, then watch it until rsp_valid
    // appears or 300 cycles pass. When intrude is set, a WRITE is offered
    // while the sequencer is busy. That WRITE must be ignored.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] d, input logic [31:0] m,
                           input bit intrude);
        int n;
        obs_rsp_n = -1;
        obs_set_first = -1;  obs_set_cnt = 0;
        obs_srch_first = -1; obs_srch_cnt = 0;
        obs_sel_first = -1;  obs_sel_cnt = 0;
        obs_wr_first = -1;   obs_wr_cnt = 0;
        obs_wl = '0; obs_wl_varies = 1'b0; obs_hit = 1'b0; obs_err = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_mask = m;
        @(negedge CLK);
        cmd_valid = 1'b0;
        for (n = 0; n < 300; n++) begin
            if (set) begin if (obs_set_cnt == 0) obs_set_first = n; obs_set_cnt++; end
            if (perform_search) begin if (obs_srch_cnt == 0) obs_srch_first = n; obs_srch_cnt++; end
            if (select_first) begin if (obs_sel_cnt == 0) obs_sel_first = n; obs_sel_cnt++; end
            if (write_lines != '0) begin
                if (obs_wr_cnt == 0) obs_wl = write_lines;
                else if (write_lines != obs_wl) obs_wl_varies = 1'b1;
                if (obs_wr_cnt == 0) obs_wr_first = n;
                obs_wr_cnt++;
            end
            if (rsp_valid) begin
                obs_rsp_n = n; obs_hit = rsp_hit; obs_err = rsp_err;
                break;
            end
            if (intrude && n == 1) begin
                cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 32'hFF; cmd_mask = 32'hFF;
            end
            if (intrude && n == 3) cmd_valid = 1'b0;
            @(negedge CLK);
        end
        $display("TXN op=%0d d=%h m=%h rsp_at=%0d hit=%0b err=%0b set=%0d/%0d srch=%0d/%0d sel=%0d/%0d wr=%0d/%0d",
                 op, d, m, obs_rsp_n, obs_hit, obs_err, obs_set_first, obs_set_cnt,
                 obs_srch_first, obs_srch_cnt, obs_sel_first, obs_sel_cnt, obs_wr_first, obs_wr_cnt);
    endtask

    task automatic test_reset();
        RST_N = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_mask = '0; tag_wires = '0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({cmd_ready, busy, set, perform_search, select_first, rsp_valid, rsp_hit, rsp_err} !== 8'b1000_0000
                || write_lines !== 64'd0 || comparand !== 32'd0 || mask !== 32'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d ready=%b busy=%b set=%b srch=%b sel=%b rsp=%b wl=%h want ready=1 rest 0",
                         i, cmd_ready, busy, set, perform_search, select_first, rsp_valid, write_lines);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_write();
        tag_wires = '0; tag_wires[2:0] = 3'b111;
        run_cmd(2'b10, 32'd5, 32'hFFFF_FFFF, 1'b0);
        checks++; if (obs_wl !== 64'hAAAA_AAAA_AAAA_AA99) begin errors++;
            $display("FAIL write_pattern got %h want aaaaaaaaaaaaaa99", obs_wl); end
        checks++; if (obs_wr_first !== 0 || obs_wr_cnt !== 10 || obs_wl_varies) begin errors++;
            $display("FAIL write_timing first=%0d cnt=%0d varies=%b want 0/10/0", obs_wr_first, obs_wr_cnt, obs_wl_varies); end
        checks++; if (obs_rsp_n !== 111) begin errors++;
            $display("FAIL write_latency got %0d want 111", obs_rsp_n); end
        checks++; if (obs_set_cnt + obs_srch_cnt + obs_sel_cnt !== 0 || obs_err !== 1'b0) begin errors++;
            $display("FAIL write_other_pulses set=%0d srch=%0d sel=%0d err=%b want 0", obs_set_cnt, obs_srch_cnt, obs_sel_cnt, obs_err); end
        checks++; if (comparand !== 32'd5 || mask !== 32'hFFFF_FFFF || cmd_ready !== 1'b1) begin errors++;
            $display("FAIL write_hold comparand=%h mask=%h ready=%b want 5/ffffffff/1", comparand, mask, cmd_ready); end
    endtask

    task automatic test_search();
        tag_wires = '0; tag_wires[2:0] = 3'b111;
        run_cmd(2'b00, 32'd0, 32'd1, 1'b0);
        checks++; if (obs_set_first !== 0 || obs_set_cnt !== 10) begin errors++;
            $display("FAIL search_set first=%0d cnt=%0d want 0/10", obs_set_first, obs_set_cnt); end
        checks++; if (obs_srch_first !== 20 || obs_srch_cnt !== 10) begin errors++;
            $display("FAIL search_srch first=%0d cnt=%0d want 20/10", obs_srch_first, obs_srch_cnt); end
        checks++; if (obs_rsp_n !== 41 || obs_hit !== 1'b1 || obs_sel_cnt !== 0) begin errors++;
            $display("FAIL search_rsp at=%0d hit=%b sel=%0d want 41/1/0", obs_rsp_n, obs_hit, obs_sel_cnt); end
        checks++; if (mask !== 32'd1 || comparand !== 32'd0) begin errors++;
            $display("FAIL search_operands comparand=%h mask=%h want 0/1", comparand, mask); end
        tag_wires = '0;
        run_cmd(2'b00, 32'hA5, 32'hFF, 1'b0);
        checks++; if (obs_rsp_n !== 41 || obs_hit !== 1'b0) begin errors++;
            $display("FAIL search_miss at=%0d hit=%b want 41/0", obs_rsp_n, obs_hit); end
    endtask

    task automatic test_select();
        tag_wires = '0; tag_wires[3:0] = 4'b0110;
        run_cmd(2'b01, 32'h1234, 32'hFFFF, 1'b0);
        checks++; if (obs_sel_first !== 0 || obs_sel_cnt !== 2) begin errors++;
            $display("FAIL select_pulse first=%0d cnt=%0d want 0/2", obs_sel_first, obs_sel_cnt); end
        checks++; if (obs_rsp_n !== 5 || obs_hit !== 1'b1) begin errors++;
            $display("FAIL select_rsp at=%0d hit=%b want 5/1", obs_rsp_n, obs_hit); end
    endtask

    task automatic test_search_select();
        tag_wires = '0; tag_wires[99] = 1'b1;
        run_cmd(2'b11, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b0);
        checks++; if (obs_set_cnt !== 10 || obs_srch_first !== 20 || obs_srch_cnt !== 10) begin errors++;
            $display("FAIL ss_search set=%0d srch=%0d/%0d want 10 20/10", obs_set_cnt, obs_srch_first, obs_srch_cnt); end
        checks++; if (obs_sel_first !== 40 || obs_sel_cnt !== 2) begin errors++;
            $display("FAIL ss_select first=%0d cnt=%0d want 40/2", obs_sel_first, obs_sel_cnt); end
        checks++; if (obs_rsp_n !== 45 || obs_hit !== 1'b1 || obs_err !== 1'b0) begin errors++;
            $display("FAIL ss_rsp at=%0d hit=%b err=%b want 45/1/0", obs_rsp_n, obs_hit, obs_err); end
    endtask

    // Busy-time command is ignored, and the next command starts immediately.
    task automatic test_back_to_back();
        tag_wires = '0; tag_wires[5] = 1'b1;
        run_cmd(2'b01, 32'h0000_0077, 32'h0000_00F0, 1'b1);
        checks++; if (obs_rsp_n !== 5 || obs_wr_cnt !== 0 || comparand !== 32'h77 || mask !== 32'hF0) begin errors++;
            $display("FAIL busy_ignore at=%0d wr=%0d comparand=%h mask=%h want 5/0/77/f0", obs_rsp_n, obs_wr_cnt, comparand, mask); end
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL ready_after_rsp ready=%b busy=%b want 1/0", cmd_ready, busy); end
        tag_wires = '0;
        run_cmd(2'b01, 32'h0, 32'h0, 1'b0);
        checks++; if (obs_rsp_n !== 5 || obs_hit !== 1'b0 || obs_sel_cnt !== 2) begin errors++;
            $display("FAIL back_to_back at=%0d hit=%b sel=%0d want 5/0/2", obs_rsp_n, obs_hit, obs_sel_cnt); end
    endtask

    task automatic test_reset_mid();
        int n;
        int rsp_seen;
        tag_wires = '0; tag_wires[0] = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 32'h3; cmd_mask = 32'h3;
        @(negedge CLK);
        cmd_valid = 1'b0;
        for (n = 0; n < 25; n++) @(negedge CLK);
        checks++; if (perform_search !== 1'b1) begin errors++;
            $display("FAIL mid_in_srch perform_search=%b want 1", perform_search); end
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        checks++; if (perform_search !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || comparand !== 32'd0) begin errors++;
            $display("FAIL mid_reset srch=%b ready=%b rsp=%b comparand=%h want 0/1/0/0", perform_search, cmd_ready, rsp_valid, comparand); end
        rsp_seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid || set || perform_search) rsp_seen++;
            @(negedge CLK);
        end
        checks++; if (rsp_seen !== 0) begin errors++;
            $display("FAIL mid_no_resume activity_cycles=%0d want 0", rsp_seen); end
        $display("TXN reset during SRCH, activity after reset=%0d", rsp_seen);
    endtask

    task automatic test_guard();
        tag_wires = '0;
        run_cmd(2'b10, 32'hF, 32'hF, 1'b0);
`ifdef CAPP_SEQ_WRITE_GUARD_EN
        checks++; if (obs_wr_cnt !== 0 || obs_rsp_n !== 1 || obs_err !== 1'b1) begin errors++;
            $display("FAIL guard_write wr=%0d at=%0d err=%b want 0/1/1", obs_wr_cnt, obs_rsp_n, obs_err); end
        run_cmd(2'b11, 32'hF, 32'hF, 1'b0);
        checks++; if (obs_sel_cnt !== 0 || obs_rsp_n !== 41 || obs_err !== 1'b1) begin errors++;
            $display("FAIL guard_ss sel=%0d at=%0d err=%b want 0/41/1", obs_sel_cnt, obs_rsp_n, obs_err); end
`else
        checks++; if (obs_wr_cnt !== 10 || obs_rsp_n !== 111 || obs_err !== 1'b0 || obs_wl !== 64'h0000_0000_0000_0055) begin errors++;
            $display("FAIL noguard_write wr=%0d at=%0d err=%b wl=%h want 10/111/0/55", obs_wr_cnt, obs_rsp_n, obs_err, obs_wl); end
        run_cmd(2'b11, 32'hF, 32'hF, 1'b0);
        checks++; if (obs_sel_cnt !== 2 || obs_rsp_n !== 45 || obs_err !== 1'b0 || obs_hit !== 1'b0) begin errors++;
            $display("FAIL noguard_ss sel=%0d at=%0d err=%b hit=%b want 2/45/0/0", obs_sel_cnt, obs_rsp_n, obs_err, obs_hit); end
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_search();
        test_select();
        test_search_select();
        test_back_to_back();
        test_reset_mid();
        test_guard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
